// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared types and helpers for the async FIFO packet writer
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        STREAM,
        DROP
    } pkt_wr_state_t;

    // Free slots as seen from the write side; ocup is pessimistic, so this never overstates space.
    function automatic int unsigned free_slots(input int unsigned ocup, input int unsigned slots);
        return (ocup >= slots) ? 0 : slots - ocup;
    endfunction

endpackage

// File: rtl/cdc_fifo_pkt_writer.sv
// rtl/cdc_fifo_pkt_writer.sv - admits whole packets into the async FIFO only when they fit
module cdc_fifo_pkt_writer
    import cdc_pkg::*;
#(
    parameter int SLOTS     = 8,
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 4,
    parameter int CNT_W     = 16
) (
    input  logic                         clk_wr,
    input  logic                         arst_wr,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    input  logic [WIDTH-1:0]             s_data_i,
    input  logic [$clog2(MAX_BEATS):0]   s_len_i,
    input  logic                         s_last_i,
    output logic                         fifo_wr_en_o,
    output logic [WIDTH-1:0]             fifo_wr_data_o,
    input  logic                         fifo_full_i,
    input  logic [$clog2(SLOTS):0]       fifo_ocup_i,
    output logic                         pkt_err_o,
    output logic [CNT_W-1:0]             pkt_cnt_o,
    output logic                         busy_o
);

    localparam int LEN_W  = $clog2(MAX_BEATS) + 1;
    localparam int OCUP_W = $clog2(SLOTS) + 1;

    pkt_wr_state_t     state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic              busy_q;

    logic [OCUP_W-1:0] free;
    logic              accept;
    logic              last_beat;
    logic              len_bad;

    assign free      = OCUP_W'(free_slots(32'(fifo_ocup_i), SLOTS));
    assign len_bad   = (s_len_i == '0) || (s_len_i > LEN_W'(MAX_BEATS));
    assign last_beat = (beat_q == len_q - 1'b1);

    // Ready is combinational so a full FIFO stalls the source in the same cycle.
    assign s_ready_o      = (state == STREAM) ? ~fifo_full_i : (state == DROP);
    assign accept         = s_valid_i & s_ready_o;
    assign fifo_wr_en_o   = (state == STREAM) & accept;
    assign fifo_wr_data_o = s_data_i;

    assign pkt_err_o = err_q;
    assign pkt_cnt_o = cnt_q;
    assign busy_o    = busy_q;

    always_ff @(posedge clk_wr or posedge arst_wr) begin
        if (arst_wr) begin
            state  <= IDLE;
            len_q  <= '0;
            beat_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid_i) begin
                        len_q  <= s_len_i;
                        busy_q <= 1'b1;
                        if (len_bad) begin
                            err_q <= 1'b1;
                            state <= DROP;
                        end else begin
                            state <= WAIT_SPACE;
                        end
                    end
                end
                WAIT_SPACE: begin
                    if (free >= OCUP_W'(len_q)) begin
                        beat_q <= '0;
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        beat_q <= beat_q + 1'b1;
                        if (s_last_i) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            if (last_beat) begin
                                cnt_q <= cnt_q + 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else if (last_beat) begin
                            // Declared length reached without last: discard the tail.
                            err_q <= 1'b1;
                            state <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (accept && s_last_i) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    a_params: assert property (@(posedge clk_wr)
        (MAX_BEATS >= 1) && (MAX_BEATS <= SLOTS) && (SLOTS >= 2) && ((SLOTS & (SLOTS - 1)) == 0));

    a_no_wr_full: assert property (@(posedge clk_wr) disable iff (arst_wr)
        !(fifo_wr_en_o && fifo_full_i));

endmodule

// File: doc/cdc_fifo_pkt_writer.md
Name: cdc_fifo_pkt_writer

Overview:
- Write-domain producer for the team's async FIFO with occupancy output: the block that drives that FIFO's write port.
- Accepts a valid/ready packet stream whose length arrives on the first beat. Admits a packet only when the FIFO has enough free slots for the whole packet, so the read side never sees a partial packet stalled mid-burst.
- Drops malformed packets and flags them. Lives entirely in clk_wr.

Parameters:
- SLOTS, 8: depth of the downstream async FIFO; power of 2, >= 2.
- WIDTH, 8: data width.
- MAX_BEATS, 4: largest legal packet length in beats; 1 <= MAX_BEATS <= SLOTS.
- CNT_W, 16: width of the packet counter.

Ports:
- clk_wr  in  1  write-domain clock
- arst_wr  in  1  reset, asynchronous, active-high
- s_valid_i  in  1  input beat valid
- s_ready_o  out  1  input beat accepted when high with s_valid_i
- s_data_i  in  WIDTH  beat data
- s_len_i  in  $clog2(MAX_BEATS)+1  packet length in beats; sampled on the first beat only
- s_last_i  in  1  final beat of packet
- fifo_wr_en_o  out  1  to FIFO wr_en_i
- fifo_wr_data_o  out  WIDTH  to FIFO wr_data_i
- fifo_full_i  in  1  from FIFO wr_full_o
- fifo_ocup_i  in  $clog2(SLOTS)+1  from FIFO ocup_o
- pkt_err_o  out  1  one-cycle pulse on a malformed packet
- pkt_cnt_o  out  CNT_W  count of packets fully written; wraps modulo 2^CNT_W
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; len_q=0, beat_q=0, pkt_cnt_o=0, pkt_err_o=0. s_ready_o and fifo_wr_en_o are 0 during reset and in IDLE.
- States: IDLE, WAIT_SPACE, STREAM, DROP. All transitions are registered on clk_wr.
- IDLE: s_ready_o=0, so the first beat is not consumed here.
  - On s_valid_i, sample s_len_i into len_q.
  - If s_len_i==0 or s_len_i>MAX_BEATS: pulse pkt_err_o next cycle and go to DROP.
  - Otherwise go to WAIT_SPACE.
- WAIT_SPACE: s_ready_o=0.
  - free = SLOTS - fifo_ocup_i, computed at $clog2(SLOTS)+1 bits with no underflow since ocup <= SLOTS.
  - If free >= len_q, go to STREAM with beat_q=0.
  - The free figure is pessimistic (the read pointer is synchronizer-delayed), so it is always safe.
- STREAM:
  - s_ready_o = ~fifo_full_i, combinational.
  - fifo_wr_en_o = s_valid_i & s_ready_o.
  - fifo_wr_data_o = s_data_i, a zero-latency passthrough.
  - fifo_full_i high should never occur after admission; if it does, stall without loss.
  - On each accepted beat, beat_q increments.
  - Accepted beat with beat_q==len_q-1 and s_last_i: pkt_cnt_o++ and go to IDLE.
  - Accepted beat with s_last_i and beat_q<len_q-1 (short packet): beats are already written; pulse pkt_err_o, no pkt_cnt increment, go to IDLE.
  - Accepted beat with beat_q==len_q-1 and no s_last_i (long packet): pulse pkt_err_o, no pkt_cnt increment, go to DROP.
- DROP:
  - s_ready_o=1 and fifo_wr_en_o=0; discard beats.
  - An accepted beat with s_last_i goes to IDLE.
- pkt_err_o: registered, high exactly one cycle per malformed packet.
- busy_o: registered from the state; 0 only in IDLE.
- Back-to-back packets: after returning to IDLE, the next packet's first beat is sampled on the following cycle. Minimum header overhead is 2 cycles (IDLE and WAIT_SPACE).
- Reset asserted mid-STREAM: immediate return to IDLE. Beats already written stay in the FIFO; resetting the FIFO pair is the system's responsibility.
- Assertions:
  - MAX_BEATS <= SLOTS and MAX_BEATS >= 1.
  - SLOTS is a power of 2.
  - fifo_wr_en_o never asserted while fifo_full_i is high.

Decomposition:
- Package cdc_pkg holds:
  - typedef enum pkt_wr_state_t {IDLE, WAIT_SPACE, STREAM, DROP};
  - a parameterized-width helper function free_slots(ocup, SLOTS).
- No sub-module; the FSM, counters and passthrough stay inline.
- The bench instantiates this block together with cdc_async_fifo_w_ocup.

Test Plan:
- Basic packet: SLOTS=8, MAX_BEATS=4, empty FIFO; packet len=3, data 0xA1,0xA2,0xA3, last on 3rd -> FIFO receives exactly 3 writes in order; pkt_cnt_o=1; pkt_err_o never high.
- Space gating: preload 6 entries (ocup=6), reader stalled; send len=4 -> s_ready_o stays 0 in WAIT_SPACE. Reader pops 2 (ocup 4 after sync delay) -> STREAM entered, 4 beats written, FIFO full, pkt_cnt_o=1.
- Illegal length: len=0, then len=5, each 2 beats with last on 2nd -> two pkt_err_o pulses; zero FIFO writes; pkt_cnt_o unchanged; both packets consumed via DROP.
- Short packet: len=4 but last on beat 2 -> 2 writes, one pkt_err_o pulse, pkt_cnt_o unchanged, back in IDLE.
- Long packet: len=2, 4 beats with last on beat 4 -> 2 writes, one pkt_err_o pulse, beats 3-4 dropped, IDLE after beat 4.
- Reset mid-STREAM: assert arst_wr after beat 1 of len=3 -> s_ready_o=0, busy_o=0, pkt_cnt_o=0 immediately. A subsequent len=1 packet is accepted normally and gives pkt_cnt_o=1.
